frame_writer: RTL
=================

Name: frame_writer

Overview:
- Write-side companion to the team's synchronous read-only memory blocks.
- Accepts a byte stream (e.g. OV7670 RGB565, two bytes per pixel) and packs byte pairs into WIDTH-bit words.
- Drives a single-port synchronous RAM write interface (wr_en/wr_addr/wr_data) with an auto-incrementing address, filling exactly DEPTH words per frame.
- Sits between the camera capture logic and the frame buffer RAM, which the display/detection path reads back.

Parameters:
- WIDTH, 16, word width written to RAM; must equal 16 (two bytes per word).
- DEPTH, 8, number of words per frame; must be ≥ 2.
- HIGH_BYTE_FIRST, 1, 1: first byte of a pair goes to wr_data[15:8]; 0: first byte goes to wr_data[7:0].
- ADDR_BITS, $clog2(DEPTH), localparam; width of the address bus.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; (re)starts a frame at address 0.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  input byte.
- wr_en  out  1  RAM write strobe, one cycle per word.
- wr_addr  out  ADDR_BITS  RAM write address, valid when wr_en=1.
- wr_data  out  WIDTH  RAM write data, valid when wr_en=1.
- busy  out  1  high in HI and LO states.
- frame_done  out  1  one-cycle pulse after the DEPTH-th word is written.
- word_count  out  ADDR_BITS+1  words written in the current/last frame.
- overflow  out  1  sticky flag: a byte arrived while not capturing after a completed frame.

Behaviour:
- Reset state:
  - On rst=1 at a clock edge: state=IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, word_count=0, overflow=0; the held first byte is cleared.
  - rst has priority over every other input.
- State machine (IDLE, HI, LO, DONE):
  - IDLE: byte_valid is ignored and does not set overflow. frame_start → HI with addr=0, word_count=0, overflow=0.
  - HI: byte_valid → hold byte_data as the first byte, go to LO.
  - LO: byte_valid → register the word and its address.
    - Next cycle: wr_en=1, wr_data={first,byte} (HIGH_BYTE_FIRST=1) or {byte,first} (=0), wr_addr=addr.
    - In that same next cycle, word_count increments.
    - If addr==DEPTH-1 → DONE; otherwise addr+1 and return to HI.
  - DONE: frame_done=1 for exactly one cycle, concurrent with the final wr_en. Then the state stays DONE, busy=0.
    - byte_valid in DONE sets overflow=1 (sticky).
    - frame_start in DONE → HI, restarting as from IDLE.
- Timing and ordering:
  - Write latency: wr_en rises 1 cycle after the second byte of a pair is accepted.
  - Back-to-back byte_valid every cycle gives a wr_en every 2 cycles. Gaps in byte_valid are allowed in any state.
  - wr_addr and wr_data hold their last values when wr_en=0. Addresses are strictly 0,1,…,DEPTH-1 per frame with no wrap inside a frame.
- Boundary conditions:
  - frame_start while in HI or LO: abort immediately.
    - The held byte is discarded, addr=0, word_count=0, state=HI.
    - frame_done is not pulsed for the aborted frame.
    - A write already registered from the previous cycle still completes (wr_en=1 with the old address).
  - frame_start and byte_valid in the same cycle: frame_start wins and the byte is dropped, because VSYNC precedes pixel data.
  - A frame_start that arrives during the frame_done cycle is honoured; frame_done still pulses.
  - word_count saturates at DEPTH and is held until the next frame_start.

Test Plan:
- Reset, then frame_start, then 16 consecutive bytes 0x00..0x0F (DEPTH=8) → 8 writes: addr 0..7, data 0x0001, 0x0203, …, 0x0E0F; wr_en every 2nd cycle; frame_done pulses with the addr-7 write; word_count=8.
- HIGH_BYTE_FIRST=0, bytes 0xAA, 0x55 → wr_data=0x55AA at addr 0, one cycle after 0x55 is accepted.
- byte_valid toggling 1,0,0,1 across a pair → single write, no spurious wr_en, data correct.
- frame_start after 5 bytes (2 words + 1 held) → held byte dropped; next two bytes write addr 0; no frame_done; word_count resets to 0.
- After frame_done, drive 3 more bytes → overflow=1, no writes; then frame_start → overflow=0, capture restarts at addr 0.
- Assert rst in LO with a held byte → all outputs 0 next cycle; subsequent bytes without frame_start produce no writes.

Source files
------------

// File: rtl/frame_writer.sv
// Packs a byte stream into WIDTH-bit words and writes one frame of DEPTH words
// to a synchronous single-port RAM with an auto-incrementing address.
module frame_writer #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned HIGH_BYTE_FIRST = 1,
  localparam int unsigned ADDR_BITS      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]     wr_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic [ADDR_BITS:0]   word_count,
  output logic                 overflow
);

  localparam int unsigned CNT_W = ADDR_BITS + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HI   = 2'd1;
  localparam logic [1:0] S_LO   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           r_state,      w_state;
  logic [ADDR_BITS-1:0] r_addr,       w_addr;
  logic [7:0]           r_first,      w_first;
  logic                 r_wr_en,      w_wr_en;
  logic [ADDR_BITS-1:0] r_wr_addr,    w_wr_addr;
  logic [WIDTH-1:0]     r_wr_data,    w_wr_data;
  logic                 r_busy,       w_busy;
  logic                 r_frame_done, w_frame_done;
  logic [CNT_W-1:0]     r_word_count, w_word_count;
  logic                 r_overflow,   w_overflow;
  logic [WIDTH-1:0]     w_word;

  // Byte order within the packed word.
  assign w_word = (HIGH_BYTE_FIRST != 0) ? WIDTH'({r_first, byte_data})
                                         : WIDTH'({byte_data, r_first});

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_first      <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_addr       <= w_addr;
      r_first      <= w_first;
      r_wr_en      <= w_wr_en;
      r_wr_addr    <= w_wr_addr;
      r_wr_data    <= w_wr_data;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
      r_word_count <= w_word_count;
      r_overflow   <= w_overflow;
    end
  end

  // Next-state and next-output logic; frame_start overrides everything (VSYNC before pixels).
  always_comb begin
    w_state      = r_state;
    w_addr       = r_addr;
    w_first      = r_first;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_wr_addr;
    w_wr_data    = r_wr_data;
    w_frame_done = 1'b0;
    w_word_count = r_word_count;
    w_overflow   = r_overflow;

    if (frame_start) begin
      w_state      = S_HI;
      w_addr       = '0;
      w_first      = '0;
      w_word_count = '0;
      w_overflow   = 1'b0;
    end else begin
      case (r_state)
        S_HI: begin
          if (byte_valid) begin
            w_first = byte_data;
            w_state = S_LO;
          end
        end
        S_LO: begin
          if (byte_valid) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_addr;
            w_wr_data = w_word;
            if (r_word_count < CNT_W'(DEPTH)) begin
              w_word_count = r_word_count + CNT_W'(1);
            end
            if (r_addr == ADDR_BITS'(DEPTH - 1)) begin
              w_state      = S_DONE;
              w_frame_done = 1'b1;
            end else begin
              w_addr  = r_addr + ADDR_BITS'(1);
              w_state = S_HI;
            end
          end
        end
        S_DONE: begin
          if (byte_valid) begin
            w_overflow = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    w_busy = (w_state == S_HI) || (w_state == S_LO);
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign word_count = r_word_count;
  assign overflow   = r_overflow;

endmodule
